// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: FSM encoding, count width and
// default primitive tap masks used by the generator and the MISR.
package lbist_pkg;

  localparam int CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COMPACT = 2'd1;
  localparam state_t ST_CHECK   = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  function automatic logic [31:0] default_taps(input int w);
    logic [31:0] m;
    case (w)
      2:       m = 32'h0000_0003;
      3:       m = 32'h0000_0003;
      4:       m = 32'h0000_0003;
      5:       m = 32'h0000_0005;
      6:       m = 32'h0000_0003;
      7:       m = 32'h0000_0003;
      8:       m = 32'h0000_001D;
      16:      m = 32'h0000_002D;
      32:      m = 32'h0000_00C5;
      default: m = 32'h0000_0003;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Shift/XOR signature register: right shift with XOR-reduced
// feedback into the MSB, response word folded in on enable.
module misr_core
  import lbist_pkg::*;
#(
  parameter int unsigned           WIDTH = 4,
  parameter logic [WIDTH-1:0]      POLY  = WIDTH'(4'b0011),
  parameter logic [WIDTH-1:0]      SEED  = '0
) (
  input  logic             clk,
  input  logic             load_seed,
  input  logic             en,
  input  logic [WIDTH-1:0] resp,
  output logic [WIDTH-1:0] sig
);

  logic             fb;
  logic [WIDTH-1:0] sig_next;

  // feedback tap parity and next signature
  always_comb begin
    fb       = ^(POLY & sig);
    sig_next = {fb, sig[WIDTH-1:1]} ^ resp;
  end

  // seed reload wins over compaction
  always_ff @(posedge clk) begin
    if (load_seed)
      sig <= SEED;
    else if (en)
      sig <= sig_next;
  end

endmodule

// File: rtl/misr_ora.sv
// MISR output response analyzer: run FSM, word count and
// golden signature compare around misr_core.
module misr_ora
  import lbist_pkg::*;
#(
  parameter int unsigned      WIDTH  = 4,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(4'b0011),
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int unsigned      NPAT   = 15,
  parameter logic [WIDTH-1:0] GOLDEN = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              valid,
  input  logic [WIDTH-1:0]  resp,
  input  logic              rpg_end,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [WIDTH-1:0]  signature,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPAT - 1);

  state_t state;
  logic   can_start;
  logic   load_seed;
  logic   take;
  logic   last;
  logic   match;

  // run control decode
  always_comb begin
    can_start = (state == ST_IDLE) || (state == ST_DONE);
    load_seed = rst || (start && can_start);
    take      = (state == ST_COMPACT) && valid;
    last      = (state == ST_COMPACT) &&
                (rpg_end || (valid && (count == LAST_IDX)));
    match     = (signature == GOLDEN);
    busy      = (state == ST_COMPACT) || (state == ST_CHECK);
    done      = (state == ST_DONE);
  end

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk       (clk),
    .load_seed (load_seed),
    .en        (take),
    .resp      (resp),
    .sig       (signature)
  );

  // run FSM, accepted-word count and registered verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      pass  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_COMPACT;
            count <= '0;
          end
        end
        ST_COMPACT: begin
          if (valid)
            count <= count + 1'b1;
          if (last)
            state <= ST_CHECK;
        end
        ST_CHECK: begin
          pass  <= match;
          fail  <= !match;
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_COMPACT;
            count <= '0;
            pass  <= 1'b0;
            fail  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_misr_ora.sv
// Directed bench for misr_ora: two instances share stimulus and
// differ only in GOLDEN (0000 and 0100).
module tb_misr_ora;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        valid;
  logic [3:0]  resp;
  logic        rpg_end;

  logic        busy_a, done_a, pass_a, fail_a;
  logic [3:0]  sig_a;
  logic [15:0] cnt_a;
  logic        busy_b, done_b, pass_b, fail_b;
  logic [3:0]  sig_b;
  logic [15:0] cnt_b;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [3:0]  sig;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  m_sig;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  misr_ora #(
    .WIDTH(4), .POLY(4'b0011), .SEED(4'b0000),
    .NPAT(15), .GOLDEN(4'b0000)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .resp(resp), .rpg_end(rpg_end),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail(fail_a), .signature(sig_a), .count(cnt_a)
  );

  misr_ora #(
    .WIDTH(4), .POLY(4'b0011), .SEED(4'b0000),
    .NPAT(15), .GOLDEN(4'b0100)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .resp(resp), .rpg_end(rpg_end),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail(fail_b), .signature(sig_b), .count(cnt_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // independent model of one compaction step
  function automatic logic [3:0] misr_step(input logic [3:0] s,
                                           input logic [3:0] r);
    logic f;
    f = s[0] ^ s[1];
    return {f, s[3], s[2], s[1]} ^ r;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_sig = 4'b0000;
    m_cnt = 16'd0;
  endtask

  task automatic send(input logic [3:0] w, input logic e);
    exp_t x;
    valid   = 1'b1;
    resp    = w;
    rpg_end = e;
    m_sig   = misr_step(m_sig, w);
    m_cnt   = m_cnt + 16'd1;
    sb.push_back('{sig: m_sig, cnt: m_cnt});
    tick();
    valid   = 1'b0;
    rpg_end = 1'b0;
    resp    = 4'b0000;
    x = sb.pop_front();
    chk("word_sig", {28'd0, sig_b}, {28'd0, x.sig});
    chk("word_cnt", {16'd0, cnt_b}, {16'd0, x.cnt});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    resp = 4'b0000; rpg_end = 1'b0;
    m_sig = 4'b0000; m_cnt = 16'd0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_pass", {31'd0, pass_a}, 32'd0);
    chk("rst_fail", {31'd0, fail_a}, 32'd0);
    chk("rst_sig",  {28'd0, sig_a}, 32'd0);
    chk("rst_cnt",  {16'd0, cnt_a}, 32'd0);

    // idle ignores valid and rpg_end
    valid = 1'b1; resp = 4'b1111; rpg_end = 1'b1;
    tick();
    valid = 1'b0; resp = 4'b0000; rpg_end = 1'b0;
    chk("idle_ign_busy", {31'd0, busy_a}, 32'd0);
    chk("idle_ign_sig", {28'd0, sig_a}, 32'd0);

    // all-zero stream of NPAT words
    do_start();
    chk("start_busy", {31'd0, busy_a}, 32'd1);
    for (int i = 0; i < 15; i++) send(4'b0000, 1'b0);
    chk("z_check_busy", {31'd0, busy_a}, 32'd1);
    chk("z_check_done", {31'd0, done_a}, 32'd0);
    tick();
    chk("z_done", {31'd0, done_a}, 32'd1);
    chk("z_busy", {31'd0, busy_a}, 32'd0);
    chk("z_sig",  {28'd0, sig_a}, 32'h0);
    chk("z_cnt",  {16'd0, cnt_a}, 32'd15);
    chk("z_pass", {31'd0, pass_a}, 32'd1);
    chk("z_fail", {31'd0, fail_a}, 32'd0);
    chk("z_fail_b", {31'd0, fail_b}, 32'd1);
    idle(3);
    chk("z_done_hold", {31'd0, done_a}, 32'd1);
    chk("z_pass_hold", {31'd0, pass_a}, 32'd1);

    // known sequence, restart from DONE; valid with start ignored
    start = 1'b1; valid = 1'b1; resp = 4'b1010;
    tick();
    start = 1'b0; valid = 1'b0; resp = 4'b0000;
    m_sig = 4'b0000; m_cnt = 16'd0;
    chk("k_busy", {31'd0, busy_b}, 32'd1);
    chk("k_cnt0", {16'd0, cnt_b}, 32'd0);
    chk("k_pass_clr", {31'd0, pass_a}, 32'd0);
    chk("k_sig0", {28'd0, sig_b}, 32'h0);
    send(4'b0001, 1'b0);
    chk("k_sig1", {28'd0, sig_b}, 32'h1);
    send(4'b0000, 1'b0);
    chk("k_sig2", {28'd0, sig_b}, 32'h8);
    send(4'b0000, 1'b1);
    chk("k_sig3", {28'd0, sig_b}, 32'h4);
    chk("k_in_check", {31'd0, done_b}, 32'd0);
    tick();
    chk("k_done", {31'd0, done_b}, 32'd1);
    chk("k_pass", {31'd0, pass_b}, 32'd1);
    chk("k_fail", {31'd0, fail_b}, 32'd0);

    // single-bit error in the second word
    do_start();
    send(4'b0001, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b0000, 1'b1);
    chk("e_sig", {28'd0, sig_b}, 32'hD);
    tick();
    chk("e_done", {31'd0, done_b}, 32'd1);
    chk("e_pass", {31'd0, pass_b}, 32'd0);
    chk("e_fail", {31'd0, fail_b}, 32'd1);

    // gapped valid; start in COMPACT ignored
    do_start();
    send(4'b0001, 1'b0);
    start = 1'b1;
    idle(3);
    start = 1'b0;
    chk("g_hold_cnt", {16'd0, cnt_b}, 32'd1);
    chk("g_hold_sig", {28'd0, sig_b}, 32'h1);
    send(4'b0000, 1'b0);
    idle(3);
    chk("g_hold_cnt2", {16'd0, cnt_b}, 32'd2);
    send(4'b0000, 1'b1);
    tick();
    chk("g_done", {31'd0, done_b}, 32'd1);
    chk("g_sig",  {28'd0, sig_b}, 32'h4);
    chk("g_cnt",  {16'd0, cnt_b}, 32'd3);
    chk("g_pass", {31'd0, pass_b}, 32'd1);

    // early end with valid=0
    do_start();
    send(4'b0001, 1'b0);
    send(4'b0000, 1'b0);
    rpg_end = 1'b1;
    tick();
    rpg_end = 1'b0;
    chk("x_check_busy", {31'd0, busy_b}, 32'd1);
    chk("x_check_done", {31'd0, done_b}, 32'd0);
    tick();
    chk("x_done", {31'd0, done_b}, 32'd1);
    chk("x_cnt",  {16'd0, cnt_b}, 32'd2);
    chk("x_sig",  {28'd0, sig_b}, 32'h8);
    chk("x_fail", {31'd0, fail_b}, 32'd1);

    // reset mid-run
    do_start();
    send(4'b0001, 1'b0);
    send(4'b0011, 1'b0);
    send(4'b0110, 1'b0);
    send(4'b1000, 1'b0);
    send(4'b0101, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_busy", {31'd0, busy_a}, 32'd0);
    chk("r_done", {31'd0, done_a}, 32'd0);
    chk("r_sig",  {28'd0, sig_a}, 32'h0);
    chk("r_cnt",  {16'd0, cnt_a}, 32'd0);
    do_start();
    for (int i = 0; i < 15; i++) send(4'b0000, 1'b0);
    tick();
    chk("r2_done", {31'd0, done_a}, 32'd1);
    chk("r2_cnt",  {16'd0, cnt_a}, 32'd15);
    chk("r2_pass", {31'd0, pass_a}, 32'd1);
    chk("r2_fail", {31'd0, fail_a}, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/misr_ora.md
# misr_ora

Multiple-input signature register (MISR) output response analyzer for the LBIST loop. It compacts each circuit-under-test response word produced while the LFSR pattern generator runs into a WIDTH-bit signature. At the end of the pattern cycle it compares the signature against a golden value and reports pass or fail to the BIST controller.

## Interface
- WIDTH, 4: response and signature bitwidth, range 2..32.
- POLY, 4'b0011: feedback tap mask; bit i set means sig[i] feeds the XOR.
- SEED, 0: signature value after reset and at every start.
- NPAT, 15: maximum number of response words compacted per run, range 1..2^16-1.
- GOLDEN, 0: expected final signature.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a run; ignored unless in IDLE or DONE.
- valid  in  1  resp is valid this cycle.
- resp  in  WIDTH  CUT response word.
- rpg_end  in  1  end-of-pattern-cycle pulse from the pattern generator.
- busy  out  1  high in COMPACT and CHECK.
- done  out  1  high in DONE.
- pass  out  1  signature == GOLDEN; meaningful only while done=1.
- fail  out  1  signature != GOLDEN; meaningful only while done=1.
- signature  out  WIDTH  current MISR contents.
- count  out  16  number of response words accepted in the current run.

## Operation
- States: IDLE, COMPACT, CHECK, DONE.
- IDLE:
  - start=1 → COMPACT; signature←SEED, count←0.
  - valid and rpg_end are ignored.
- COMPACT, on valid=1:
  - fb = XOR-reduce(POLY & signature).
  - signature ← {fb, signature[WIDTH-1:1]} ^ resp.
  - count ← count+1.
  - valid=0 holds signature and count.
- COMPACT exits to CHECK when either holds this cycle:
  - valid=1 and count==NPAT-1 (NPAT-th word accepted); or
  - rpg_end=1. If valid=1 in the same cycle, that word is compacted first.
  - Both conditions together cause a single transition.
- rpg_end with valid=0 terminates the run without compacting anything.
- CHECK: one cycle. Registers pass←(signature==GOLDEN) and fail←!pass, then moves to DONE.
- DONE:
  - Holds signature, count, pass and fail.
  - start=1 → COMPACT with SEED reload, count←0, pass←0, fail←0.
- start is ignored in COMPACT and CHECK; a run cannot be restarted mid-way.
- rst at any point: state←IDLE, signature←SEED, count←0, pass=fail=0. Any partial signature is discarded.
- Arithmetic:
  - count is unsigned 16-bit and cannot wrap because NPAT ≤ 2^16-1.
  - Signature arithmetic is GF(2) only; there is no carry.

## Timing
- Reset values: busy=0, done=0, pass=0, fail=0, signature=SEED, count=0.
- start in cycle t → busy=1 in t+1.
- First compaction happens on the first valid=1 edge at or after t+1. valid in cycle t itself is ignored.
- signature and count reflect a word accepted in cycle t from t+1.
- Terminating word accepted in cycle t:
  - CHECK occupies t+1.
  - done=1 with valid pass/fail from t+2.
  - Total latency from last word to result is 2 cycles.
- done is a level and stays high until start or rst.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package lbist_pkg holds:
  - The state enum.
  - Default primitive tap masks per width, shared with the generator.
  - The 16-bit count width constant.
- Sub-module misr_core (WIDTH, POLY, SEED) implements the shift/XOR register with load_seed and enable inputs.
- misr_ora wraps misr_core with the FSM, count and compare logic.

## Test plan
- All-zero stream: WIDTH=4, POLY=0011, SEED=0, GOLDEN=0, 15 words of resp=0000 → done at last-word+2, signature=0000, count=15, pass=1, fail=0.
- Known sequence: resp 0001, 0000, 0000 then rpg_end with the third word, GOLDEN=0100 → signature after each word 0001, 1000, 0100; pass=1.
- Single-bit error: same as the previous case but second word 0010 → signature ≠ 0100 after the third word; fail=1, pass=0.
- Gapped valid: the known-sequence words with 3 idle cycles between each → same 0100 result; count increments only on valid cycles.
- Early end: rpg_end with valid=0 after 2 words (0001, 0000) → count=2, signature=1000, CHECK then DONE.
- Reset mid-run: rst asserted after 5 words → next cycle IDLE, signature=SEED, count=0, busy=0. A later start runs cleanly to pass on the all-zero stream.
